// File: rtl/rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_bus_arbiter
//
// Purpose:
//   Owns the RTC multiplexed address/data bus and shares it between N_REQ
//   requesters. Requester 0 is the init FSM. An idle arbiter grants one
//   requester in round-robin order. It then runs a complete two-phase bus
//   cycle for that requester:
//     ADDR -> ADDR_GAP -> DATA -> DATA_GAP
//   A one-cycle done pulse goes to the owner at the end of the bus cycle.
//   Every output is registered.
//
// Ports:
//   clk_i      clock, rising edge
//   reset      synchronous, active-high reset
//   req        per-requester request, held until the matching done bit
//   req_we     per-requester direction: 1 = write, 0 = read
//   req_addr   per-requester RTC register address, slice [8i+7:8i]
//   req_wdata  per-requester write data, slice [8i+7:8i]
//   grant      one-hot owner of the current bus cycle
//   done       one-hot, one-cycle pulse at the end of the owner's cycle
//   rdata      data captured in the last read cycle, valid with done
//   busy       high while a bus cycle is in progress
//   ad_out     value driven onto the AD bus
//   ad_oe      1 = drive the AD bus from ad_out, 0 = tristate
//   ad_in      sampled AD bus value
//   a_d        0 = address phase, 1 = data phase
//   rd_n       RTC read strobe, active low
//   wr_n       RTC write strobe, active low
//   cs_n       RTC chip select, active low
// -----------------------------------------------------------------------------
module rtc_bus_arbiter #(
  parameter int N_REQ    = 3,
  parameter int T_STROBE = 7,
  parameter int T_GAP    = 7
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_we,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         rdata,
  output logic               busy,
  output logic [7:0]         ad_out,
  output logic               ad_oe,
  input  logic [7:0]         ad_in,
  output logic               a_d,
  output logic               rd_n,
  output logic               wr_n,
  output logic               cs_n
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int T_MAX = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(T_GAP - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_GAP = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_DATA_GAP = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_ptr;
  logic             r_we;
  logic [7:0]       r_wdata;

  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic [7:0]       r_rdata;
  logic             r_busy;
  logic [7:0]       r_ad_out;
  logic             r_ad_oe;
  logic             r_a_d;
  logic             r_rd_n;
  logic             r_wr_n;
  logic             r_cs_n;

  logic             w_any;
  logic [PTR_W-1:0] w_winner;
  logic [N_REQ-1:0] w_onehot;
  logic             w_sel_we;
  logic [7:0]       w_sel_addr;
  logic [7:0]       w_sel_wdata;
  logic             w_cnt_zero;

  // Round-robin search. It starts at pointer+1 and walks upward, wrapping
  // past N_REQ-1. The first request found wins.
  // NOTE: every always_comb output gets a default first. Without the
  // defaults, a path that leaves one unassigned infers a latch.
  always_comb begin
    w_any       = 1'b0;
    w_winner    = '0;
    w_onehot    = '0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 1; k <= N_REQ; k++) begin : g_search
      int idx;
      idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_any && req[idx]) begin
        w_any         = 1'b1;
        w_winner      = PTR_W'(idx);
        w_onehot[idx] = 1'b1;
        w_sel_we      = req_we[idx];
        w_sel_addr    = req_addr[8*idx +: 8];
        w_sel_wdata   = req_wdata[8*idx +: 8];
      end
    end
  end

  assign w_cnt_zero = (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // register samples pre-edge values and the outputs update together.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= PTR_W'(N_REQ - 1);
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_ad_out <= '0;
      r_ad_oe  <= 1'b0;
      r_a_d    <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_cs_n   <= 1'b1;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant  <= w_onehot;
            r_busy   <= 1'b1;
            r_ptr    <= w_winner;
            r_we     <= w_sel_we;
            r_wdata  <= w_sel_wdata;
            // The address phase starts on the grant edge. Address latching
            // uses WR# as its strobe.
            r_ad_out <= w_sel_addr;
            r_ad_oe  <= 1'b1;
            r_a_d    <= 1'b0;
            r_cs_n   <= 1'b0;
            r_wr_n   <= 1'b0;
            r_rd_n   <= 1'b1;
            r_cnt    <= STROBE_LOAD;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_cnt_zero) begin
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_cnt   <= GAP_LOAD;
            r_state <= S_ADDR_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ADDR_GAP: begin
          if (w_cnt_zero) begin
            r_a_d  <= 1'b1;
            r_cs_n <= 1'b0;
            if (r_we) begin
              r_ad_out <= r_wdata;
              r_ad_oe  <= 1'b1;
              r_wr_n   <= 1'b0;
            end else begin
              // The RTC drives the bus during a read, so release it.
              r_ad_oe <= 1'b0;
              r_rd_n  <= 1'b0;
            end
            r_cnt   <= STROBE_LOAD;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_cnt_zero) begin
            // Capture on the final RD# cycle, while the RTC is still driving.
            if (!r_we) begin
              r_rdata <= ad_in;
            end
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_ad_oe <= r_we;
            r_cnt   <= GAP_LOAD;
            r_state <= S_DATA_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA_GAP: begin
          if (w_cnt_zero) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ad_oe <= 1'b0;
            r_a_d   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant  = r_grant;
  assign done   = r_done;
  assign rdata  = r_rdata;
  assign busy   = r_busy;
  assign ad_out = r_ad_out;
  assign ad_oe  = r_ad_oe;
  assign a_d    = r_a_d;
  assign rd_n   = r_rd_n;
  assign wr_n   = r_wr_n;
  assign cs_n   = r_cs_n;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_arbiter
//
// Drives rtc_bus_arbiter with directed requests.
// A transaction-level model predicts the bus timeline of each granted
// transaction, using only the offset from the grant edge. Each cycle the DUT
// outputs are compared against that prediction.
// Hand-computed literals pin latency, ordering and strobe shapes.
// A second instance with T_STROBE = T_GAP = 1 covers the minimum timing.
// -----------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

  localparam int N  = 3;
  localparam int TS = 7;
  localparam int TG = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  req_we;
  logic [8*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic [7:0]    rdata;
  logic          busy;
  logic [7:0]    ad_out;
  logic          ad_oe;
  logic [7:0]    ad_in;
  logic          a_d;
  logic          rd_n;
  logic          wr_n;
  logic          cs_n;

  logic [N-1:0]   f_req;
  logic [N-1:0]   f_req_we;
  logic [8*N-1:0] f_req_addr;
  logic [8*N-1:0] f_req_wdata;
  logic [N-1:0]   f_grant;
  logic [N-1:0]   f_done;
  logic [7:0]     f_rdata;
  logic           f_busy;
  logic [7:0]     f_ad_out;
  logic           f_ad_oe;
  logic [7:0]     f_ad_in;
  logic           f_a_d;
  logic           f_rd_n;
  logic           f_wr_n;
  logic           f_cs_n;

  rtc_bus_arbiter #(.N_REQ(N), .T_STROBE(TS), .T_GAP(TG)) u_dut (
    .clk_i(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .busy(busy), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .a_d(a_d), .rd_n(rd_n), .wr_n(wr_n), .cs_n(cs_n)
  );

  rtc_bus_arbiter #(.N_REQ(N), .T_STROBE(1), .T_GAP(1)) u_fast (
    .clk_i(clk), .reset(reset), .req(f_req), .req_we(f_req_we),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .grant(f_grant),
    .done(f_done), .rdata(f_rdata), .busy(f_busy), .ad_out(f_ad_out),
    .ad_oe(f_ad_oe), .ad_in(f_ad_in), .a_d(f_a_d), .rd_n(f_rd_n),
    .wr_n(f_wr_n), .cs_n(f_cs_n)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model. It holds the owner and the number of edges since
  // the grant edge. The bus phase is derived from that offset.
  // ---------------------------------------------------------------------------
  bit          m_valid = 1'b0;
  bit          m_rst_edge;
  bit          m_active;
  int          m_t;
  int          m_owner;
  int          m_ptr;
  bit          m_we;
  logic [7:0]  m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic [N-1:0] m_done;

  always @(posedge clk) begin
    m_rst_edge = reset;
    if (reset) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_t      = 0;
      m_ptr    = N - 1;
      m_rdata  = 8'h00;
      m_done   = '0;
    end else begin
      m_done = '0;
      if (m_active) begin
        if (m_t == 2*TS + TG - 1 && !m_we) m_rdata = ad_in;
        m_t++;
        if (m_t == 2*(TS + TG)) begin
          m_active         = 1'b0;
          m_done[m_owner]  = 1'b1;
        end
      end else if (req != '0) begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (!found && req[i]) begin
            found   = 1'b1;
            m_owner = i;
          end
        end
        m_ptr    = m_owner;
        m_active = 1'b1;
        m_t      = 0;
        m_we     = req_we[m_owner];
        m_addr   = req_addr[8*m_owner +: 8];
        m_wdata  = req_wdata[8*m_owner +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process (negedge). It also acts as the RTC driving AD while RD#
  // is low, and logs grant events.
  // ---------------------------------------------------------------------------
  logic [7:0]    rtc_val = 8'h00;
  int            ncyc = 0;
  logic [N-1:0]  prev_grant = '0;
  logic          prev_cs = 1'b1;
  logic          prev_ad = 1'b1;
  logic [7:0]    prev_out = 8'h00;
  logic [N-1:0]  g_log[$];
  int            g_cyc[$];

  always @(negedge clk) begin
    ncyc++;
    if (m_valid) begin
      int   ph;
      logic e_cs, e_wr, e_rd, e_ad, e_oe;
      logic [7:0] e_out;
      logic [N-1:0] e_grant;
      if (m_active) begin
        ph = (m_t < TS) ? 0 : (m_t < TS + TG) ? 1 : (m_t < 2*TS + TG) ? 2 : 3;
        e_cs    = !(ph == 0 || ph == 2);
        e_wr    = !(ph == 0 || (ph == 2 && m_we));
        e_rd    = !(ph == 2 && !m_we);
        e_ad    = (ph >= 2);
        e_oe    = (ph < 2) || m_we;
        e_out   = (ph < 2) ? m_addr : m_wdata;
        e_grant = N'(1) << m_owner;
      end else begin
        e_cs = 1'b1; e_wr = 1'b1; e_rd = 1'b1; e_ad = 1'b1; e_oe = 1'b0;
        e_out = 8'h00; e_grant = '0;
      end
      check("grant", 32'(grant), 32'(e_grant));
      check("busy",  32'(busy),  32'(m_active));
      check("done",  32'(done),  32'(m_done));
      check("rdata", 32'(rdata), 32'(m_rdata));
      check("cs_n",  32'(cs_n),  32'(e_cs));
      check("wr_n",  32'(wr_n),  32'(e_wr));
      check("rd_n",  32'(rd_n),  32'(e_rd));
      check("a_d",   32'(a_d),   32'(e_ad));
      check("ad_oe", 32'(ad_oe), 32'(e_oe));
      if (e_oe) check("ad_out", 32'(ad_out), 32'(e_out));
      check("grant_onehot", 32'($onehot0(grant)), 32'd1);
      check("strobe_rule", 32'(!cs_n && !rd_n && !wr_n), 32'd0);
      if (!m_rst_edge && (a_d !== prev_ad || ad_out !== prev_out))
        check("ad_change_cs_high", 32'(prev_cs), 32'd1);
    end
    if (grant != '0 && prev_grant == '0) begin
      g_log.push_back(grant);
      g_cyc.push_back(ncyc);
    end
    prev_grant = grant;
    prev_cs    = cs_n;
    prev_ad    = a_d;
    prev_out   = ad_out;
    ad_in      = rd_n ? 8'hEE : rtc_val;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  // Waits for grant[idx], then measures the bus cycle up to done[idx] and
  // drops the request.
  task automatic observe(input int idx, input bit we, input logic [7:0] addr,
                         output int lat, output int n_addr, output int n_data,
                         output int n_rdlow, output logic [7:0] rd_at_done);
    int waited;
    waited = 0; lat = 0; n_addr = 0; n_data = 0; n_rdlow = 0; rd_at_done = 8'h00;
    while (!grant[idx] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!grant[idx]) begin
      check("grant_timeout", 32'd0, 32'd1);
      req[idx] = 1'b0;
      return;
    end
    while (!done[idx] && lat < 200) begin
      if (!cs_n && !a_d && !wr_n && rd_n && ad_out == addr) n_addr++;
      if (!cs_n && a_d && (we ? (!wr_n && rd_n && ad_oe) : (!rd_n && wr_n && !ad_oe))) n_data++;
      if (!rd_n) n_rdlow++;
      @(negedge clk);
      lat++;
    end
    if (!done[idx]) check("done_timeout", 32'd0, 32'd1);
    rd_at_done = rdata;
    req[idx]   = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int waited;
    waited = 0;
    while (g_log.size() < n && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (g_log.size() < n) check("grant_log_timeout", 32'(g_log.size()), 32'(n));
  endtask

  initial begin
    int lat, n_addr, n_data, n_rdlow;
    logic [7:0] rd;
    logic [4:0] cs_v, wr_v, ad_v, dn_v, rd_v;
    int waited;

    reset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    f_req = '0; f_req_we = '0; f_req_addr = '0; f_req_wdata = '0; f_ad_in = 8'h00;
    tick(2);
    check("rst_grant",  32'(grant),  32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_rdata",  32'(rdata),  32'd0);
    check("rst_ad_out", 32'(ad_out), 32'd0);
    check("rst_ad_oe",  32'(ad_oe),  32'd0);
    check("rst_a_d",    32'(a_d),    32'd1);
    check("rst_strobes", 32'({cs_n, rd_n, wr_n}), 32'b111);
    reset = 1'b0;
    tick(1);

    // 1: write by requester 1.
    req_we[1] = 1'b1; req_addr[15:8] = 8'h21; req_wdata[15:8] = 8'h00;
    req[1] = 1'b1;
    observe(1, 1'b1, 8'h21, lat, n_addr, n_data, n_rdlow, rd);
    check("t1_latency",   32'(lat),     32'd28);
    check("t1_addr_cyc",  32'(n_addr),  32'd7);
    check("t1_data_cyc",  32'(n_data),  32'd7);
    check("t1_rd_low",    32'(n_rdlow), 32'd0);
    tick(3);

    // 2: read by requester 2.
    rtc_val = 8'h45;
    req_we[2] = 1'b0; req_addr[23:16] = 8'h23;
    req[2] = 1'b1;
    observe(2, 1'b0, 8'h23, lat, n_addr, n_data, n_rdlow, rd);
    check("t2_latency",  32'(lat),     32'd28);
    check("t2_addr_cyc", 32'(n_addr),  32'd7);
    check("t2_data_cyc", 32'(n_data),  32'd7);
    check("t2_rd_low",   32'(n_rdlow), 32'd7);
    check("t2_rdata",    32'(rd),      32'h45);
    tick(3);

    // 3: contention from reset, all three held.
    req_we = 3'b101; req_addr = 24'h0A_0B_0C; req_wdata = 24'h1A_1B_1C;
    do_reset();
    g_log.delete(); g_cyc.delete();
    req = 3'b111;
    wait_grants(4);
    if (g_log.size() >= 4) begin
      check("t3_grant0", 32'(g_log[0]), 32'b001);
      check("t3_grant1", 32'(g_log[1]), 32'b010);
      check("t3_grant2", 32'(g_log[2]), 32'b100);
      check("t3_grant3", 32'(g_log[3]), 32'b001);
      for (int i = 0; i < 3; i++)
        check("t3_spacing", 32'(g_cyc[i+1] - g_cyc[i]), 32'd29);
    end
    req = '0;
    tick(35);

    // 4: requesters 0 and 2 held, rotation must alternate.
    do_reset();
    g_log.delete(); g_cyc.delete();
    req = 3'b101;
    wait_grants(4);
    if (g_log.size() >= 4) begin
      check("t4_grant0", 32'(g_log[0]), 32'b001);
      check("t4_grant1", 32'(g_log[1]), 32'b100);
      check("t4_grant2", 32'(g_log[2]), 32'b001);
      check("t4_grant3", 32'(g_log[3]), 32'b100);
    end
    req = '0;
    tick(35);

    // 5: reset during the DATA phase of a write.
    req_we[1] = 1'b1; req_addr[15:8] = 8'h30; req_wdata[15:8] = 8'h5A;
    req[1] = 1'b1;
    waited = 0;
    while (!(grant[1] && !cs_n && a_d) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("t5_reached_data", 32'(grant[1] && !cs_n && a_d), 32'd1);
    tick(2);
    g_log.delete(); g_cyc.delete();
    reset = 1'b1;
    tick(1);
    check("t5_cs_n",  32'(cs_n),  32'd1);
    check("t5_wr_n",  32'(wr_n),  32'd1);
    check("t5_ad_oe", 32'(ad_oe), 32'd0);
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_busy",  32'(busy),  32'd0);
    check("t5_done",  32'(done),  32'd0);
    reset = 1'b0;
    req = 3'b011;
    wait_grants(1);
    if (g_log.size() >= 1) check("t5_first_after_reset", 32'(g_log[0]), 32'b001);
    observe(0, req_we[0], req_addr[7:0], lat, n_addr, n_data, n_rdlow, rd);
    req = '0;
    tick(35);

    // 6: minimum timing instance; offsets 0..4 from the first grant sample.
    f_req_we[0] = 1'b1; f_req_addr[7:0] = 8'h11; f_req_wdata[7:0] = 8'h22;
    f_req[0] = 1'b1;
    waited = 0;
    while (!f_grant[0] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("t6_granted", 32'(f_grant), 32'b001);
    for (int i = 0; i < 5; i++) begin
      cs_v[i] = f_cs_n; wr_v[i] = f_wr_n; ad_v[i] = f_a_d;
      dn_v[i] = f_done[0]; rd_v[i] = f_rd_n;
      if (i == 0) check("t6_addr_out", 32'(f_ad_out), 32'h11);
      if (i == 2) check("t6_data_out", 32'(f_ad_out), 32'h22);
      if (i < 4) @(negedge clk);
    end
    f_req[0] = 1'b0;
    check("t6_cs_shape",  32'(cs_v), 32'b11010);
    check("t6_wr_shape",  32'(wr_v), 32'b11010);
    check("t6_ad_shape",  32'(ad_v), 32'b11100);
    check("t6_rd_shape",  32'(rd_v), 32'b11111);
    check("t6_done_at4",  32'(dn_v), 32'b10000);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
